exa_crosb_output_vc_state: RTL and testbench

EXA_CROSB_OUTPUT_VC_STATE -- requirements
Module: exa_crosb_output_vc_state

---
 rtl/exanet_crosb_pkg.sv | 15 +
 rtl/exa_crosb_vc_credit_cnt.sv | 78 +++++++
 rtl/exa_crosb_output_vc_state.sv | 98 +++++++++
 tb/tb_exa_crosb_output_vc_state.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exanet_crosb_pkg.sv
// Shared types for the crossbar output-VC state tracking.
// Contents: per-VC FSM state enum and the credit-count storage type.
package exanet_crosb_pkg;

  // Per-output-VC allocation state.
  typedef enum logic {
    VC_FREE = 1'b0,
    VC_BUSY = 1'b1
  } vc_state_e;

  // Credit counter storage; wide enough for any supported credit_max (<= 255).
  localparam int unsigned CREDIT_W = 8;
  typedef logic [CREDIT_W-1:0] credit_cnt_t;

endpackage : exanet_crosb_pkg

// File: rtl/exa_crosb_vc_credit_cnt.sv
// One output VC: FREE/BUSY ownership FSM plus downstream credit counter.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   req, req_owner    allocation request already decoded for this VC
//   flit, tail        flit departing on this VC, tail marker
//   credit            downstream credit returned for this VC
//   grant_c           combinational: request is granted this cycle
//   err_c             combinational: illegal departure or credit overflow this cycle
//   free              VC is in FREE state
//   credit_avail      credit count is nonzero
//   owner             input VC recorded at the last grant
module exa_crosb_vc_credit_cnt
  import exanet_crosb_pkg::*;
#(
  parameter int unsigned credit_max = 8,
  parameter int unsigned owner_w    = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req,
  input  logic [owner_w-1:0] req_owner,
  input  logic               flit,
  input  logic               tail,
  input  logic               credit,
  output logic               grant_c,
  output logic               err_c,
  output logic               free,
  output logic               credit_avail,
  output logic [owner_w-1:0] owner
);

  localparam credit_cnt_t CNT_MAX = credit_cnt_t'(credit_max);

  vc_state_e   state;
  credit_cnt_t cnt;
  logic        flit_ok;
  logic        flit_bad;
  logic        credit_ovf;

  // A grant needs a FREE VC with room downstream; a tail this cycle leaves the
  // VC BUSY until the edge, so a same-cycle request is denied naturally.
  assign grant_c    = req && (state == VC_FREE) && (cnt != '0);

  // Departures are only legal on an owned VC holding a credit; illegal ones
  // are flagged and otherwise ignored.
  assign flit_ok    = flit && (state == VC_BUSY) && (cnt != '0);
  assign flit_bad   = flit && !flit_ok;

  // A credit paired with a legal departure is net zero and cannot overflow.
  assign credit_ovf = credit && !flit_ok && (cnt == CNT_MAX);
  assign err_c      = flit_bad || credit_ovf;

  assign free         = (state == VC_FREE);
  assign credit_avail = (cnt != '0);

  // State, owner and credit count registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= VC_FREE;
      owner <= '0;
      cnt   <= CNT_MAX;
    end else begin
      if (grant_c) begin
        state <= VC_BUSY;
        owner <= req_owner;
      end else if (flit_ok && tail) begin
        state <= VC_FREE;
      end

      if (flit_ok && !credit) begin
        cnt <= cnt - credit_cnt_t'(1);
      end else if (credit && !flit_ok && (cnt != CNT_MAX)) begin
        cnt <= cnt + credit_cnt_t'(1);
      end
    end
  end

endmodule : exa_crosb_vc_credit_cnt

// File: rtl/exa_crosb_output_vc_state.sv
// Output-VC allocation and credit state for one crossbar output port.
// Ports:
//   clk, resetn                              clock, synchronous active-low reset
//   i_req_valid/i_req_vc/i_req_owner         VC allocation request
//   o_gnt_valid/o_gnt_vc/o_gnt_owner         one-cycle registered grant
//   i_flit_valid/i_flit_vc/i_flit_tail       flit departure
//   i_credit_valid/i_credit_vc               downstream credit return
//   o_vc_free, o_credit_avail, o_owner       per-VC state views
//   o_err                                    sticky protocol error
module exa_crosb_output_vc_state
  import exanet_crosb_pkg::*;
#(
  parameter  int unsigned prio_num   = 2,
  parameter  int unsigned vc_num     = 2,
  parameter  int unsigned credit_max = 8,
  parameter  int unsigned logVcPrio  = $clog2(prio_num * vc_num),
  localparam int unsigned NVC        = prio_num * vc_num
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          i_req_valid,
  input  logic [logVcPrio-1:0]          i_req_vc,
  input  logic [logVcPrio-1:0]          i_req_owner,
  output logic                          o_gnt_valid,
  output logic [logVcPrio-1:0]          o_gnt_vc,
  output logic [logVcPrio-1:0]          o_gnt_owner,
  input  logic                          i_flit_valid,
  input  logic [logVcPrio-1:0]          i_flit_vc,
  input  logic                          i_flit_tail,
  input  logic                          i_credit_valid,
  input  logic [logVcPrio-1:0]          i_credit_vc,
  output logic [NVC-1:0]                o_vc_free,
  output logic [NVC-1:0]                o_credit_avail,
  output logic [NVC-1:0][logVcPrio-1:0] o_owner,
  output logic                          o_err
);

  logic           req_oob_c;
  logic [NVC-1:0] grant_c;
  logic [NVC-1:0] err_c;

  // Out-of-range request detection only exists when the index field can
  // encode more values than there are VCs.
  if ((1 << logVcPrio) > NVC) begin : g_oob
    assign req_oob_c = i_req_valid && (32'(i_req_vc) >= NVC);
  end else begin : g_no_oob
    assign req_oob_c = 1'b0;
  end

  // Per-VC decode and state instance.
  for (genvar v = 0; v < NVC; v++) begin : g_vc
    logic req_hit;
    logic flit_hit;
    logic credit_hit;

    assign req_hit    = i_req_valid && !req_oob_c && (i_req_vc == logVcPrio'(v));
    assign flit_hit   = i_flit_valid && (i_flit_vc == logVcPrio'(v));
    assign credit_hit = i_credit_valid && (i_credit_vc == logVcPrio'(v));

    exa_crosb_vc_credit_cnt #(
      .credit_max (credit_max),
      .owner_w    (logVcPrio)
    ) u_vc (
      .clk          (clk),
      .resetn       (resetn),
      .req          (req_hit),
      .req_owner    (i_req_owner),
      .flit         (flit_hit),
      .tail         (i_flit_tail),
      .credit       (credit_hit),
      .grant_c      (grant_c[v]),
      .err_c        (err_c[v]),
      .free         (o_vc_free[v]),
      .credit_avail (o_credit_avail[v]),
      .owner        (o_owner[v])
    );
  end

  // Grant pulse and sticky error; at most one VC can grant per cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_gnt_valid <= 1'b0;
      o_gnt_vc    <= '0;
      o_gnt_owner <= '0;
      o_err       <= 1'b0;
    end else begin
      o_gnt_valid <= |grant_c;
      if (|grant_c) begin
        o_gnt_vc    <= i_req_vc;
        o_gnt_owner <= i_req_owner;
      end
      if (req_oob_c || (|err_c)) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule : exa_crosb_output_vc_state

// File: tb/tb_exa_crosb_output_vc_state.sv
// Directed bench for exa_crosb_output_vc_state with default parameters (4 VCs, 8 credits).
module tb_exa_crosb_output_vc_state;

  localparam int unsigned NVC = 4;
  localparam int unsigned VW  = 2;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b0;
  logic                   i_req_valid = 1'b0;
  logic [VW-1:0]          i_req_vc = '0;
  logic [VW-1:0]          i_req_owner = '0;
  logic                   o_gnt_valid;
  logic [VW-1:0]          o_gnt_vc;
  logic [VW-1:0]          o_gnt_owner;
  logic                   i_flit_valid = 1'b0;
  logic [VW-1:0]          i_flit_vc = '0;
  logic                   i_flit_tail = 1'b0;
  logic                   i_credit_valid = 1'b0;
  logic [VW-1:0]          i_credit_vc = '0;
  logic [NVC-1:0]         o_vc_free;
  logic [NVC-1:0]         o_credit_avail;
  logic [NVC-1:0][VW-1:0] o_owner;
  logic                   o_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  exa_crosb_output_vc_state dut (
    .clk            (clk),
    .resetn         (resetn),
    .i_req_valid    (i_req_valid),
    .i_req_vc       (i_req_vc),
    .i_req_owner    (i_req_owner),
    .o_gnt_valid    (o_gnt_valid),
    .o_gnt_vc       (o_gnt_vc),
    .o_gnt_owner    (o_gnt_owner),
    .i_flit_valid   (i_flit_valid),
    .i_flit_vc      (i_flit_vc),
    .i_flit_tail    (i_flit_tail),
    .i_credit_valid (i_credit_valid),
    .i_credit_vc    (i_credit_vc),
    .o_vc_free      (o_vc_free),
    .o_credit_avail (o_credit_avail),
    .o_owner        (o_owner),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req_valid    = 1'b0;
    i_flit_valid   = 1'b0;
    i_flit_tail    = 1'b0;
    i_credit_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  task automatic req(input int vc, input int own);
    i_req_valid = 1'b1;
    i_req_vc    = VW'(vc);
    i_req_owner = VW'(own);
    cyc();
    idle();
  endtask

  task automatic flit(input int vc, input logic tail);
    i_flit_valid = 1'b1;
    i_flit_vc    = VW'(vc);
    i_flit_tail  = tail;
    cyc();
    idle();
  endtask

  task automatic credit(input int vc);
    i_credit_valid = 1'b1;
    i_credit_vc    = VW'(vc);
    cyc();
    idle();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_free",   32'(o_vc_free), 32'h0000_000f);
    check("rst_avail",  32'(o_credit_avail), 32'h0000_000f);
    check("rst_gnt",    32'(o_gnt_valid), 32'd0);
    check("rst_gnt_vc", 32'(o_gnt_vc), 32'd0);
    check("rst_gnt_ow", 32'(o_gnt_owner), 32'd0);
    check("rst_owner",  32'(o_owner), 32'd0);
    check("rst_err",    32'(o_err), 32'd0);

    // Grant VC2 to owner 1, single-cycle pulse, busy VC denies
    req(2, 1);
    check("g2_valid", 32'(o_gnt_valid), 32'd1);
    check("g2_vc",    32'(o_gnt_vc), 32'd2);
    check("g2_owner", 32'(o_gnt_owner), 32'd1);
    check("g2_free",  32'(o_vc_free), 32'b1011);
    check("g2_own2",  32'(o_owner[2]), 32'd1);
    cyc();
    check("g2_pulse", 32'(o_gnt_valid), 32'd0);
    req(2, 3);
    check("busy_deny",   32'(o_gnt_valid), 32'd0);
    check("busy_keepow", 32'(o_owner[2]), 32'd1);
    check("busy_err",    32'(o_err), 32'd0);

    // Drain VC0 credits, then an extra departure errors without wrapping
    do_reset();
    req(0, 3);
    check("g0_valid", 32'(o_gnt_valid), 32'd1);
    for (int i = 0; i < 7; i++) flit(0, 1'b0);
    check("drain7_avail", 32'(o_credit_avail[0]), 32'd1);
    flit(0, 1'b0);
    check("drain8_avail", 32'(o_credit_avail[0]), 32'd0);
    check("drain8_err",   32'(o_err), 32'd0);
    flit(0, 1'b0);
    check("drain9_err",   32'(o_err), 32'd1);
    check("drain9_avail", 32'(o_credit_avail[0]), 32'd0);
    credit(0);
    check("nowrap_cr1", 32'(o_credit_avail[0]), 32'd1);
    flit(0, 1'b0);
    check("nowrap_cr0", 32'(o_credit_avail[0]), 32'd0);
    check("err_sticky", 32'(o_err), 32'd1);

    // Tail and request on the same VC: denied, retried next cycle succeeds
    do_reset();
    req(1, 2);
    check("g1_valid", 32'(o_gnt_valid), 32'd1);
    i_flit_valid = 1'b1;
    i_flit_vc    = VW'(1);
    i_flit_tail  = 1'b1;
    i_req_valid  = 1'b1;
    i_req_vc     = VW'(1);
    i_req_owner  = VW'(0);
    cyc();
    idle();
    check("tail_deny",  32'(o_gnt_valid), 32'd0);
    check("tail_free",  32'(o_vc_free[1]), 32'd1);
    check("tail_keepo", 32'(o_owner[1]), 32'd2);
    req(1, 0);
    check("retry_valid", 32'(o_gnt_valid), 32'd1);
    check("retry_vc",    32'(o_gnt_vc), 32'd1);
    check("retry_owner", 32'(o_owner[1]), 32'd0);
    check("retry_free",  32'(o_vc_free[1]), 32'd0);
    check("retry_err",   32'(o_err), 32'd0);

    // VC3 at 5 credits: simultaneous departure and return is net zero
    do_reset();
    req(3, 1);
    for (int i = 0; i < 3; i++) flit(3, 1'b0);
    i_flit_valid   = 1'b1;
    i_flit_vc      = VW'(3);
    i_credit_valid = 1'b1;
    i_credit_vc    = VW'(3);
    cyc();
    idle();
    check("net0_err", 32'(o_err), 32'd0);
    for (int i = 0; i < 4; i++) flit(3, 1'b0);
    check("net0_4left", 32'(o_credit_avail[3]), 32'd1);
    flit(3, 1'b0);
    check("net0_5used", 32'(o_credit_avail[3]), 32'd0);
    check("net0_err2",  32'(o_err), 32'd0);

    // Credit return at full count saturates and errors
    do_reset();
    credit(0);
    check("sat_err",  32'(o_err), 32'd1);
    req(0, 0);
    check("sat_gnt", 32'(o_gnt_valid), 32'd1);
    for (int i = 0; i < 7; i++) flit(0, 1'b0);
    check("sat_7used", 32'(o_credit_avail[0]), 32'd1);
    flit(0, 1'b0);
    check("sat_8used", 32'(o_credit_avail[0]), 32'd0);

    // Departure on a FREE VC is an error and changes nothing
    do_reset();
    flit(1, 1'b1);
    check("freeflit_err",   32'(o_err), 32'd1);
    check("freeflit_free",  32'(o_vc_free), 32'h0000_000f);
    check("freeflit_avail", 32'(o_credit_avail), 32'h0000_000f);

    // FREE VC with zero credits must deny; a returned credit re-enables it
    do_reset();
    req(3, 2);
    for (int i = 0; i < 7; i++) flit(3, 1'b0);
    flit(3, 1'b1);
    check("z_free",  32'(o_vc_free[3]), 32'd1);
    check("z_avail", 32'(o_credit_avail[3]), 32'd0);
    req(3, 1);
    check("z_deny", 32'(o_gnt_valid), 32'd0);
    credit(3);
    req(3, 1);
    check("z_grant", 32'(o_gnt_valid), 32'd1);
    check("z_err",   32'(o_err), 32'd0);

    // Reset mid-packet with VC2 BUSY at 3 credits and a pending request
    do_reset();
    credit(1);
    req(2, 3);
    for (int i = 0; i < 5; i++) flit(2, 1'b0);
    check("mid_err_pre", 32'(o_err), 32'd1);
    resetn      = 1'b0;
    i_req_valid = 1'b1;
    i_req_vc    = VW'(0);
    i_req_owner = VW'(1);
    cyc();
    idle();
    check("mid_free",  32'(o_vc_free), 32'b1111);
    check("mid_avail", 32'(o_credit_avail), 32'b1111);
    check("mid_err",   32'(o_err), 32'd0);
    check("mid_gnt",   32'(o_gnt_valid), 32'd0);
    check("mid_owner", 32'(o_owner), 32'd0);
    resetn = 1'b1;
    cyc();
    check("mid_nogrant", 32'(o_gnt_valid), 32'd0);
    req(2, 1);
    for (int i = 0; i < 7; i++) flit(2, 1'b0);
    check("mid_full7", 32'(o_credit_avail[2]), 32'd1);
    flit(2, 1'b0);
    check("mid_full8", 32'(o_credit_avail[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_exa_crosb_output_vc_state
